// File: rtl/hcsr04_echo_emulator_pkg.sv
// Shared types and default timing for the HC-SR04 echo emulator and its benches.
// Clamp and width helpers keep the range arithmetic in one place.
package hcsr04_echo_emulator_pkg;

  localparam int unsigned CNT_W   = 22;
  localparam int unsigned DIST_W  = 9;
  localparam int unsigned STATE_W = 4;

  localparam int unsigned TRIG_MIN_CYCLES_DEF   = 500;
  localparam int unsigned RESP_DELAY_CYCLES_DEF = 2000;
  localparam int unsigned CYCLES_PER_CM_DEF     = 2941;
  localparam int unsigned MIN_CM_DEF            = 2;
  localparam int unsigned MAX_CM_DEF            = 400;
  localparam int unsigned HOLDOFF_CYCLES_DEF    = 3000000;
  localparam int unsigned TIMEOUT_CYCLES_DEF    = 1900000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_TRIG_HIGH = 4'd1,
    ST_DELAY     = 4'd2,
    ST_ECHO      = 4'd3,
    ST_HOLDOFF   = 4'd4,
    ST_RSVD      = 4'd5
  } state_e;

  function automatic logic [DIST_W-1:0] clamp_cm(input logic [DIST_W-1:0] d,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
    int unsigned dv;
    dv = 32'(d);
    if (dv < lo) begin
      dv = lo;
    end else if (dv > hi) begin
      dv = hi;
    end
    return DIST_W'(dv);
  endfunction

  // Fits in CNT_W for the full legal range; the top checks this at elaboration.
  function automatic logic [CNT_W-1:0] echo_cycles(input logic [DIST_W-1:0] d,
                                                   input int unsigned cpc);
    return CNT_W'(d) * CNT_W'(cpc);
  endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_if.sv
// Sensor-side signal bundle: the initiator (master) drives trigger/enable/distance,
// the emulator (slave) returns echo plus status.
interface hcsr04_echo_emulator_if;
  import hcsr04_echo_emulator_pkg::*;

  logic                 enable;
  logic [DIST_W-1:0]    distance_cm;
  logic                 trigger;
  logic                 echo;
  logic                 busy;
  logic                 trig_short;
  logic [STATE_W-1:0]   db_estado;

  modport master (
    output enable, distance_cm, trigger,
    input  echo, busy, trig_short, db_estado
  );

  modport slave (
    input  enable, distance_cm, trigger,
    output echo, busy, trig_short, db_estado
  );

endinterface

// File: rtl/hcsr04_echo_emulator_trigger_sync_edge.sv
// 2-FF synchronizer on the asynchronous trigger pin with registered one-cycle rise/fall pulses
// (pulses appear 3 cycles after the pin); no backpressure.
module hcsr04_echo_emulator_trigger_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic trigger_async,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  logic [2:0] fill_q,  fill_d;
  logic       rise_q,  rise_d;
  logic       fall_q,  fall_d;

  // Edges are suppressed until the history register holds a real pin sample,
  // so a trigger held high through reset does not look like a fresh rising edge.
  always_comb begin
    sync1_d = trigger_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[1:0], 1'b1};
    rise_d  = fill_q[2] &  sync2_q & ~prev_q;
    fall_d  = fill_q[2] & ~sync2_q &  prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates the trigger width, waits RESP_DELAY, then emits an echo of distance*CYCLES_PER_CM
// cycles followed by a hold-off; triggers outside IDLE are ignored. HCSR04_EMU_TIMEOUT_EN turns over-range into a timeout echo.
module hcsr04_echo_emulator
  import hcsr04_echo_emulator_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYCLES   = TRIG_MIN_CYCLES_DEF,
  parameter int unsigned RESP_DELAY_CYCLES = RESP_DELAY_CYCLES_DEF,
  parameter int unsigned CYCLES_PER_CM     = CYCLES_PER_CM_DEF,
  parameter int unsigned MIN_CM            = MIN_CM_DEF,
  parameter int unsigned MAX_CM            = MAX_CM_DEF,
  parameter int unsigned HOLDOFF_CYCLES    = HOLDOFF_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  hcsr04_echo_emulator_if.slave  sensor
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if ((MAX_CM * CYCLES_PER_CM) >= (32'd1 << CNT_W) || TIMEOUT_CYCLES >= (32'd1 << CNT_W) ||
      TIMEOUT_CYCLES == 0 || RESP_DELAY_CYCLES == 0 || HOLDOFF_CYCLES == 0 ||
      TRIG_MIN_CYCLES == 0 || CYCLES_PER_CM == 0 || MIN_CM == 0 || MIN_CM > MAX_CM ||
      MAX_CM >= (32'd1 << DIST_W)) begin : g_param_err
    $error("hcsr04_echo_emulator: timing parameters out of range");
  end

  logic trig_rise, trig_fall;

  hcsr04_echo_emulator_trigger_sync_edge u_sync (
    .clock         (clock),
    .reset         (reset),
    .trigger_async (sensor.trigger),
    .rise          (trig_rise),
    .fall          (trig_fall)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [DIST_W-1:0] dist_q,  dist_d;
  logic              echo_q,  echo_d;
  logic              trig_short_q, trig_short_d;
  logic [CNT_W-1:0]  echo_w;
`ifdef HCSR04_EMU_TIMEOUT_EN
  logic              noobj_q, noobj_d;
`endif

`ifdef HCSR04_EMU_TIMEOUT_EN
  always_comb begin
    echo_w = noobj_q ? CNT_W'(TIMEOUT_CYCLES) : echo_cycles(dist_q, CYCLES_PER_CM);
  end
`else
  always_comb begin
    echo_w = echo_cycles(dist_q, CYCLES_PER_CM);
  end
`endif

  // One down-counter times DELAY, ECHO and HOLDOFF; each state loads N-1 on entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    width_d      = width_q;
    dist_d       = dist_q;
    trig_short_d = 1'b0;
`ifdef HCSR04_EMU_TIMEOUT_EN
    noobj_d      = noobj_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trig_rise && sensor.enable) begin
          state_d = ST_TRIG_HIGH;
          width_d = ONE;
        end
      end
      ST_TRIG_HIGH: begin
        if (trig_fall) begin
          if (width_q >= CNT_W'(TRIG_MIN_CYCLES)) begin
            state_d = ST_DELAY;
            cnt_d   = CNT_W'(RESP_DELAY_CYCLES - 1);
            dist_d  = clamp_cm(sensor.distance_cm, MIN_CM, MAX_CM);
`ifdef HCSR04_EMU_TIMEOUT_EN
            noobj_d = (32'(sensor.distance_cm) > MAX_CM);
`endif
          end else begin
            state_d      = ST_IDLE;
            trig_short_d = 1'b1;
          end
        end else if (width_q < CNT_W'(TRIG_MIN_CYCLES)) begin
          width_d = width_q + ONE;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = ST_ECHO;
          cnt_d   = echo_w - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_ECHO: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == ST_ECHO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      width_q      <= '0;
      dist_q       <= '0;
      echo_q       <= 1'b0;
      trig_short_q <= 1'b0;
`ifdef HCSR04_EMU_TIMEOUT_EN
      noobj_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      dist_q       <= dist_d;
      echo_q       <= echo_d;
      trig_short_q <= trig_short_d;
`ifdef HCSR04_EMU_TIMEOUT_EN
      noobj_q      <= noobj_d;
`endif
    end
  end

  assign sensor.echo       = echo_q;
  assign sensor.busy       = (state_q != ST_IDLE);
  assign sensor.trig_short = trig_short_q;
  assign sensor.db_estado  = state_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Scoreboard bench for hcsr04_echo_emulator: expected echoes/short pulses are queued when a trigger
// is driven and compared when the DUT produces them.
module tb_hcsr04_echo_emulator;
  import hcsr04_echo_emulator_pkg::*;

  localparam int TRIG_MIN   = 5;
  localparam int RESP_DELAY = 10;
  localparam int CPC        = 4;
  localparam int HOLDOFF    = 50;
  localparam int TIMEOUT    = 2000;
  localparam int MINC       = 2;
  localparam int MAXC       = 400;
  localparam int ECHO_LAT   = RESP_DELAY + 3;
  localparam int SHORT_LAT  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  hcsr04_echo_emulator_if bus ();

  hcsr04_echo_emulator #(
    .TRIG_MIN_CYCLES   (TRIG_MIN),
    .RESP_DELAY_CYCLES (RESP_DELAY),
    .CYCLES_PER_CM     (CPC),
    .MIN_CM            (MINC),
    .MAX_CM            (MAXC),
    .HOLDOFF_CYCLES    (HOLDOFF),
    .TIMEOUT_CYCLES    (TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .sensor (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int fall_cyc;
    int width;
  } echo_exp_t;

  echo_exp_t echo_sb[$];
  int        short_sb[$];
  int        n_checks = 0;
  int        n_errors = 0;
  int        echo_fall_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_width(input int d);
    int dd;
    dd = d;
    if (dd < MINC) dd = MINC;
    if (dd > MAXC) begin
`ifdef HCSR04_EMU_TIMEOUT_EN
      return TIMEOUT;
`else
      dd = MAXC;
`endif
    end
    return dd * CPC;
  endfunction

  // Output monitor: pops the scoreboard on each echo fall and each trig_short pulse.
  bit echo_prev  = 1'b0;
  bit short_prev = 1'b0;
  int rise_cyc   = 0;
  int short_run  = 0;
  always @(negedge clock) begin : mon
    echo_exp_t e;
    if (bus.echo && !echo_prev) rise_cyc = cyc;
    if (!bus.echo && echo_prev) begin
      echo_fall_cyc = cyc;
      if (echo_sb.size() == 0) begin
        chk("echo_unexpected_width", cyc - rise_cyc, 0);
      end else begin
        e = echo_sb.pop_front();
        chk("echo_delay", rise_cyc - e.fall_cyc, ECHO_LAT);
        chk("echo_width", cyc - rise_cyc, e.width);
      end
    end
    if (bus.trig_short) begin
      short_run++;
      if (!short_prev) begin
        if (short_sb.size() == 0) chk("short_unexpected_cyc", cyc, -1);
        else chk("short_time", cyc, short_sb.pop_front());
      end
    end else if (short_prev) begin
      chk("short_len", short_run, 1);
      short_run = 0;
    end
    echo_prev  = bus.echo;
    short_prev = bus.trig_short;
  end

  task automatic pulse(input int width, input bit exp_echo, input bit exp_short);
    echo_exp_t e;
    @(negedge clock);
    bus.trigger = 1'b1;
    repeat (width) @(negedge clock);
    bus.trigger = 1'b0;
    e.fall_cyc = cyc + 1;
    e.width    = model_width(int'(bus.distance_cm));
    if (exp_echo) echo_sb.push_back(e);
    if (exp_short) short_sb.push_back(cyc + 1 + SHORT_LAT);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clock);
      if (!bus.busy && !bus.echo && echo_sb.size() == 0 && short_sb.size() == 0) done = 1'b1;
    end
    chk({tag, "_reach_idle"}, int'(done), 1);
  endtask

  task automatic wait_state(input string tag, input int st);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clock);
      if (int'(bus.db_estado) == st) done = 1'b1;
    end
    chk({tag, "_reach_state"}, int'(done), 1);
  endtask

  task automatic wait_echo(input string tag, input bit lvl);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clock);
      if (bus.echo == lvl) done = 1'b1;
    end
    chk({tag, "_echo_level"}, int'(done), 1);
  endtask

  int dist_tab[8] = '{10, 0, 1, 2, 400, 401, 500, 511};
  int trig_tab[8] = '{5,  8, 8, 8, 8,   8,   8,   8};

  initial begin
    bus.enable      = 1'b1;
    bus.distance_cm = 9'd10;
    bus.trigger     = 1'b0;
    reset           = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_echo",       int'(bus.echo),       0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_trig_short", int'(bus.trig_short), 0);
    chk("rst_db_estado",  int'(bus.db_estado),  0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Nominal measurement; distance change after the latch must not matter.
    bus.distance_cm = 9'd10;
    pulse(8, 1'b1, 1'b0);
    wait_state("t1_delay", int'(ST_DELAY));
    bus.distance_cm = 9'd100;
    wait_idle("t1");
    chk("t1_busy_fall", cyc - echo_fall_cyc, HOLDOFF);

    // Short triggers, including one just under the minimum.
    pulse(3, 1'b0, 1'b1);
    wait_idle("t2_w3");
    chk("t2_state", int'(bus.db_estado), 0);
    pulse(TRIG_MIN - 1, 1'b0, 1'b1);
    wait_idle("t2_w4");

    // Distance clamps and minimum accepted trigger width.
    for (int i = 0; i < 8; i++) begin
      bus.distance_cm = 9'(dist_tab[i]);
      pulse(trig_tab[i], 1'b1, 1'b0);
      wait_idle("t3");
    end

    // Retriggers during ECHO and HOLDOFF are ignored.
    bus.distance_cm = 9'd10;
    pulse(8, 1'b1, 1'b0);
    wait_echo("t4_hi", 1'b1);
    pulse(8, 1'b0, 1'b0);
    wait_echo("t4_lo", 1'b0);
    pulse(8, 1'b0, 1'b0);
    chk("t4_in_holdoff", int'(bus.db_estado), int'(ST_HOLDOFF));
    wait_idle("t4_ign");
    pulse(8, 1'b1, 1'b0);
    wait_idle("t4_next");

    // Reset in the 20th echo cycle, trigger held high across it.
    pulse(8, 1'b1, 1'b0);
    wait_echo("t5_hi", 1'b1);
    repeat (19) @(negedge clock);
    echo_sb[0].width = 20;
    bus.trigger = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_echo_after_rst", int'(bus.echo), 0);
    chk("t5_db_after_rst",   int'(bus.db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("t5_held_busy", int'(bus.busy), 0);
    bus.trigger = 1'b0;
    repeat (10) @(negedge clock);
    chk("t5_release_busy", int'(bus.busy), 0);
    pulse(8, 1'b1, 1'b0);
    wait_idle("t5_next");

    // enable gating: blocked in IDLE, ignored once the measurement started.
    bus.enable = 1'b0;
    pulse(8, 1'b0, 1'b0);
    repeat (30) @(negedge clock);
    chk("t6_blocked_busy", int'(bus.busy), 0);
    chk("t6_blocked_db",   int'(bus.db_estado), 0);
    bus.enable = 1'b1;
    pulse(8, 1'b1, 1'b0);
    wait_state("t6_delay", int'(ST_DELAY));
    bus.enable = 1'b0;
    wait_idle("t6");
    bus.enable = 1'b1;

    repeat (5) @(negedge clock);
    chk("echo_sb_drained",  echo_sb.size(),  0);
    chk("short_sb_drained", short_sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
